sprite_compositor: RTL and testbench

Pixel-generation stage that sits between the physics coprocessor and the VGA controller. Physics or processor writes each fighter's screen position, animation frame, facing and enable into shadow registers. These commit to active registers at each frame boundary. For every pixel coordinate requested by the VGA scan path, the block hit-tests both fighter sprites, fetches their texels from synchronous sprite ROMs, resolves priority and transparency, and returns a colour index. It also reports a per-frame fighter-overlap (collision) flag back to the physics coprocessor.

---
 rtl/sprite_compositor.sv | 213 +++++++++++++++++++++
 tb/tb_sprite_compositor.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Two-sprite compositor: shadow/active sprite registers, hit test, ROM addressing,
// priority/transparency resolve and per-frame collision reporting.
// Three-stage pipeline: hit test -> ROM access -> resolve.
module sprite_compositor #(
  parameter int unsigned             X_BITS      = 10,
  parameter int unsigned             Y_BITS      = 9,
  parameter int unsigned             COLOR_BITS  = 8,
  parameter logic [COLOR_BITS-1:0]   TRANSPARENT = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pos_wr_en,
  input  logic                  pos_wr_sel,
  input  logic [X_BITS-1:0]     pos_wr_x,
  input  logic [Y_BITS-1:0]     pos_wr_y,
  input  logic [1:0]            pos_wr_frame,
  input  logic                  pos_wr_flip,
  input  logic                  pos_wr_en_spr,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [X_BITS-1:0]     pix_x,
  input  logic [Y_BITS-1:0]     pix_y,
  output logic [11:0]           rom_addr0,
  output logic [11:0]           rom_addr1,
  input  logic [COLOR_BITS-1:0] rom_data0,
  input  logic [COLOR_BITS-1:0] rom_data1,
  output logic                  out_valid,
  output logic [COLOR_BITS-1:0] out_color,
  output logic                  out_opaque,
  output logic                  out_sprite,
  output logic                  collision
);

  // Sprite extent (32) widened by one bit so the right/bottom edge never wraps.
  localparam logic [X_BITS:0] SprW = {{(X_BITS - 5){1'b0}}, 6'd32};
  localparam logic [Y_BITS:0] SprH = {{(Y_BITS - 5){1'b0}}, 6'd32};

  logic [X_BITS-1:0] sh_x_q [2];
  logic [X_BITS-1:0] sh_x_d [2];
  logic [X_BITS-1:0] act_x_q [2];
  logic [Y_BITS-1:0] sh_y_q [2];
  logic [Y_BITS-1:0] sh_y_d [2];
  logic [Y_BITS-1:0] act_y_q [2];
  logic [1:0]        sh_frame_q [2];
  logic [1:0]        sh_frame_d [2];
  logic [1:0]        act_frame_q [2];
  logic [1:0]        sh_flip_q, sh_flip_d, act_flip_q;
  logic [1:0]        sh_en_q, sh_en_d, act_en_q;

  logic [1:0]  in_x, in_y, hit;
  logic [4:0]  x_off [2];
  logic [4:0]  y_off [2];
  logic [4:0]  col [2];
  logic [11:0] addr_d [2];
  logic [11:0] rom_addr_q [2];

  logic       s1_valid_q, s2_valid_q;
  logic [1:0] s1_hit_q, s2_hit_q;

  logic [1:0]            op;
  logic                  overlap;
  logic [COLOR_BITS-1:0] res_color;
  logic                  res_opaque, res_sprite;
  logic                  acc_q;

  // Shadow next-state: a write replaces all fields of the selected sprite.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sh_x_d[i]     = sh_x_q[i];
      sh_y_d[i]     = sh_y_q[i];
      sh_frame_d[i] = sh_frame_q[i];
    end
    sh_flip_d = sh_flip_q;
    sh_en_d   = sh_en_q;
    if (pos_wr_en) begin
      sh_x_d[pos_wr_sel]     = pos_wr_x;
      sh_y_d[pos_wr_sel]     = pos_wr_y;
      sh_frame_d[pos_wr_sel] = pos_wr_frame;
      sh_flip_d[pos_wr_sel]  = pos_wr_flip;
      sh_en_d[pos_wr_sel]    = pos_wr_en_spr;
    end
  end

  // Shadow/active registers; commit uses shadow next-state so a coincident write wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sh_x_q[i]      <= '0;
        sh_y_q[i]      <= '0;
        sh_frame_q[i]  <= '0;
        act_x_q[i]     <= '0;
        act_y_q[i]     <= '0;
        act_frame_q[i] <= '0;
      end
      sh_flip_q  <= '0;
      sh_en_q    <= '0;
      act_flip_q <= '0;
      act_en_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sh_x_q[i]     <= sh_x_d[i];
        sh_y_q[i]     <= sh_y_d[i];
        sh_frame_q[i] <= sh_frame_d[i];
      end
      sh_flip_q <= sh_flip_d;
      sh_en_q   <= sh_en_d;
      if (frame_start) begin
        for (int i = 0; i < 2; i++) begin
          act_x_q[i]     <= sh_x_d[i];
          act_y_q[i]     <= sh_y_d[i];
          act_frame_q[i] <= sh_frame_d[i];
        end
        act_flip_q <= sh_flip_d;
        act_en_q   <= sh_en_d;
      end
    end
  end

  // Stage 1 combinational hit test and texel address per sprite.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // Low five bits of the offset are all the address needs.
      x_off[i]  = pix_x[4:0] - act_x_q[i][4:0];
      y_off[i]  = pix_y[4:0] - act_y_q[i][4:0];
      in_x[i]   = ({1'b0, pix_x} >= {1'b0, act_x_q[i]}) &&
                  ({1'b0, pix_x} < ({1'b0, act_x_q[i]} + SprW));
      in_y[i]   = ({1'b0, pix_y} >= {1'b0, act_y_q[i]}) &&
                  ({1'b0, pix_y} < ({1'b0, act_y_q[i]} + SprH));
      hit[i]    = act_en_q[i] & in_x[i] & in_y[i];
      col[i]    = act_flip_q[i] ? ~x_off[i] : x_off[i];
      addr_d[i] = {act_frame_q[i], y_off[i], col[i]};
    end
  end

  // Stage 1 register: ROM address only moves on a valid hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_hit_q      <= '0;
      rom_addr_q[0] <= '0;
      rom_addr_q[1] <= '0;
    end else begin
      s1_valid_q <= pix_valid;
      s1_hit_q   <= pix_valid ? hit : 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (pix_valid && hit[i]) rom_addr_q[i] <= addr_d[i];
      end
    end
  end

  assign rom_addr0 = rom_addr_q[0];
  assign rom_addr1 = rom_addr_q[1];

  // Stage 2 register: carry valid/hit alongside the ROM read.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= s1_hit_q;
    end
  end

  // Stage 3 resolve: sprite 0 wins, transparent texels fall through.
  always_comb begin
    op[0]      = s2_hit_q[0] && (rom_data0 != TRANSPARENT);
    op[1]      = s2_hit_q[1] && (rom_data1 != TRANSPARENT);
    overlap    = s2_valid_q && op[0] && op[1];
    res_color  = TRANSPARENT;
    res_opaque = 1'b0;
    res_sprite = 1'b0;
    if (op[0]) begin
      res_color  = rom_data0;
      res_opaque = 1'b1;
    end else if (op[1]) begin
      res_color  = rom_data1;
      res_opaque = 1'b1;
      res_sprite = 1'b1;
    end
  end

  // Output register; colour fields hold across invalid cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_color  <= TRANSPARENT;
      out_opaque <= 1'b0;
      out_sprite <= 1'b0;
    end else begin
      out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        out_color  <= res_color;
        out_opaque <= res_opaque;
        out_sprite <= res_sprite;
      end
    end
  end

  // Collision accumulator, published and cleared at each frame boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= acc_q | overlap;
      acc_q     <= 1'b0;
    end else begin
      acc_q <= acc_q | overlap;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed steps from the test plan, then a random
// run compared every cycle against a behavioural model and a modelled sync ROM.
module tb_sprite_compositor;

  logic        clock, reset;
  logic        pos_wr_en, pos_wr_sel;
  logic [9:0]  pos_wr_x;
  logic [8:0]  pos_wr_y;
  logic [1:0]  pos_wr_frame;
  logic        pos_wr_flip, pos_wr_en_spr, frame_start, pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] rom_addr0, rom_addr1;
  logic [7:0]  rom_data0, rom_data1;
  logic        out_valid, out_opaque, out_sprite, collision;
  logic [7:0]  out_color;

  sprite_compositor dut (
    .clock        (clock),
    .reset        (reset),
    .pos_wr_en    (pos_wr_en),
    .pos_wr_sel   (pos_wr_sel),
    .pos_wr_x     (pos_wr_x),
    .pos_wr_y     (pos_wr_y),
    .pos_wr_frame (pos_wr_frame),
    .pos_wr_flip  (pos_wr_flip),
    .pos_wr_en_spr(pos_wr_en_spr),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .rom_addr0    (rom_addr0),
    .rom_addr1    (rom_addr1),
    .rom_data0    (rom_data0),
    .rom_data1    (rom_data1),
    .out_valid    (out_valid),
    .out_color    (out_color),
    .out_opaque   (out_opaque),
    .out_sprite   (out_sprite),
    .collision    (collision)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Sprite ROM contents, shared by the ROM model and the reference model.
  logic [7:0] rom0 [4096];
  logic [7:0] rom1 [4096];

  // Synchronous ROMs: data one cycle after the address.
  always @(posedge clock) begin
    rom_data0 <= rom0[rom_addr0];
    rom_data1 <= rom1[rom_addr1];
  end

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int       due;
    bit       valid;
    bit [7:0] color;
    bit       opaque;
    bit       sprite;
    bit       both;
  } exp_t;

  exp_t     expq[$];
  int       cyc = 0;
  int       sh_x[2], sh_y[2], sh_fr[2], m_x[2], m_y[2], m_fr[2], m_addr[2];
  bit       sh_flip[2], sh_en[2], m_flip[2], m_en[2];
  bit       exp_valid, exp_opaque, exp_sprite, exp_coll, m_acc;
  bit [7:0] exp_color;

  task automatic model_step();
    exp_t     e;
    bit       ov, hit, op0, op1;
    int       col, row, a;
    bit [7:0] t0, t1;
    cyc++;
    if (reset) begin
      expq.delete();
      exp_valid = 0; exp_color = 0; exp_opaque = 0; exp_sprite = 0;
      exp_coll = 0; m_acc = 0;
      for (int s = 0; s < 2; s++) begin
        sh_x[s] = 0; sh_y[s] = 0; sh_fr[s] = 0; sh_flip[s] = 0; sh_en[s] = 0;
        m_x[s] = 0; m_y[s] = 0; m_fr[s] = 0; m_flip[s] = 0; m_en[s] = 0; m_addr[s] = 0;
      end
      return;
    end
    // Pixel resolving at this edge.
    ov = 0;
    exp_valid = 0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      exp_valid = e.valid;
      if (e.valid) begin
        exp_color = e.color; exp_opaque = e.opaque; exp_sprite = e.sprite; ov = e.both;
      end
    end
    if (frame_start) begin
      exp_coll = m_acc | ov;
      m_acc = 0;
    end else begin
      m_acc = m_acc | ov;
    end
    // New pixel, evaluated against the active set before any commit at this edge.
    e.due = cyc + 2; e.valid = pix_valid; e.color = 0; e.opaque = 0; e.sprite = 0; e.both = 0;
    op0 = 0; op1 = 0; t0 = 0; t1 = 0;
    if (pix_valid) begin
      for (int s = 0; s < 2; s++) begin
        hit = m_en[s] && int'(pix_x) >= m_x[s] && int'(pix_x) < m_x[s] + 32 &&
              int'(pix_y) >= m_y[s] && int'(pix_y) < m_y[s] + 32;
        if (hit) begin
          col = int'(pix_x) - m_x[s];
          if (m_flip[s]) col = 31 - col;
          row = int'(pix_y) - m_y[s];
          a = m_fr[s] * 1024 + row * 32 + col;
          m_addr[s] = a;
          if (s == 0) begin t0 = rom0[a]; op0 = (t0 != 0); end
          else        begin t1 = rom1[a]; op1 = (t1 != 0); end
        end
      end
      if (op0)      begin e.color = t0; e.opaque = 1; end
      else if (op1) begin e.color = t1; e.opaque = 1; e.sprite = 1; end
      e.both = op0 && op1;
    end
    expq.push_back(e);
    if (pos_wr_en) begin
      sh_x[pos_wr_sel] = int'(pos_wr_x);  sh_y[pos_wr_sel] = int'(pos_wr_y);
      sh_fr[pos_wr_sel] = int'(pos_wr_frame);
      sh_flip[pos_wr_sel] = pos_wr_flip; sh_en[pos_wr_sel] = pos_wr_en_spr;
    end
    if (frame_start) begin
      for (int s = 0; s < 2; s++) begin
        m_x[s] = sh_x[s]; m_y[s] = sh_y[s]; m_fr[s] = sh_fr[s];
        m_flip[s] = sh_flip[s]; m_en[s] = sh_en[s];
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (check_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_color", 32'(out_color), 32'(exp_color));
      chk("out_opaque", 32'(out_opaque), 32'(exp_opaque));
      chk("out_sprite", 32'(out_sprite), 32'(exp_sprite));
      chk("collision", 32'(collision), 32'(exp_coll));
      chk("rom_addr0", 32'(rom_addr0), 32'(m_addr[0]));
      chk("rom_addr1", 32'(rom_addr1), 32'(m_addr[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic set_wr(input bit sel, input int x, input int y, input int fr,
                        input bit flip, input bit en);
    pos_wr_en = 1; pos_wr_sel = sel; pos_wr_x = 10'(x); pos_wr_y = 9'(y);
    pos_wr_frame = 2'(fr); pos_wr_flip = flip; pos_wr_en_spr = en;
  endtask

  task automatic wr(input bit sel, input int x, input int y, input int fr,
                    input bit flip, input bit en);
    set_wr(sel, x, y, fr, flip, en);
    tick(1);
    pos_wr_en = 0;
  endtask

  task automatic fs();
    frame_start = 1;
    tick(1);
    frame_start = 0;
  endtask

  task automatic drive_pix(input int x, input int y);
    pix_valid = 1; pix_x = 10'(x); pix_y = 9'(y);
    tick(1);
    pix_valid = 0;
  endtask

  initial begin
    pos_wr_en = 0; pos_wr_sel = 0; pos_wr_x = 0; pos_wr_y = 0; pos_wr_frame = 0;
    pos_wr_flip = 0; pos_wr_en_spr = 0; frame_start = 0;
    for (int a = 0; a < 4096; a++) begin rom0[a] = 8'h00; rom1[a] = 8'h00; end
    rom0[12'h865] = 8'h1C;
    rom0[12'h003] = 8'h55;
    rom0[12'h0A6] = 8'h03;
    rom1[12'h0A5] = 8'hE0;
    rom1[12'h0A6] = 8'hE0;
    rom1[12'h000] = 8'h77;
    rom1[12'h001] = 8'h42;

    // Reset held two cycles with pixel requests present.
    reset = 1; pix_valid = 1; pix_x = 10'd5; pix_y = 9'd5;
    tick(1);
    check_en = 1;
    tick(1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_color", 32'(out_color), 32'h00);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_rom_addr0", 32'(rom_addr0), 32'd0);
    reset = 0;

    // No sprite enabled: everything transparent.
    for (int i = 0; i < 5; i++) drive_pix(i * 40, i * 30);
    tick(2);
    chk("idle_valid", 32'(out_valid), 32'd1);
    chk("idle_opaque", 32'(out_opaque), 32'd0);
    chk("idle_color", 32'(out_color), 32'h00);

    // Basic hit.
    wr(0, 100, 50, 2, 0, 1);
    fs();
    drive_pix(105, 53);
    chk("hit_addr", 32'(rom_addr0), 32'h865);
    tick(2);
    chk("hit_color", 32'(out_color), 32'h1C);
    chk("hit_opaque", 32'(out_opaque), 32'd1);
    chk("hit_sprite", 32'(out_sprite), 32'd0);

    // Horizontal flip.
    wr(0, 100, 50, 2, 1, 1);
    fs();
    drive_pix(100, 50);
    chk("flip_addr", 32'(rom_addr0), 32'h81F);

    // Right-edge clipping.
    wr(0, 1020, 50, 0, 0, 1);
    fs();
    drive_pix(1023, 50);
    chk("clip_addr", 32'(rom_addr0), 32'h003);
    tick(2);
    chk("clip_hit_color", 32'(out_color), 32'h55);
    drive_pix(0, 50);
    tick(2);
    chk("clip_x0_opaque", 32'(out_opaque), 32'd0);
    drive_pix(28, 50);
    tick(2);
    chk("clip_x28_opaque", 32'(out_opaque), 32'd0);
    chk("clip_addr_hold", 32'(rom_addr0), 32'h003);

    // Priority and transparency, then collision reporting.
    wr(0, 200, 100, 0, 0, 1);
    wr(1, 200, 100, 0, 0, 1);
    fs();
    drive_pix(205, 105);
    tick(2);
    chk("prio_t0_color", 32'(out_color), 32'hE0);
    chk("prio_t0_sprite", 32'(out_sprite), 32'd1);
    drive_pix(206, 105);
    tick(2);
    chk("prio_o0_color", 32'(out_color), 32'h03);
    chk("prio_o0_sprite", 32'(out_sprite), 32'd0);
    chk("pre_fs_collision", 32'(collision), 32'd0);
    fs();
    chk("collision_set", 32'(collision), 32'd1);
    tick(3);
    fs();
    chk("collision_clear", 32'(collision), 32'd0);

    // Shadow registers only take effect at frame_start; coincident write wins.
    wr(1, 10, 10, 0, 0, 1);
    drive_pix(10, 10);
    tick(2);
    chk("shadow_miss", 32'(out_opaque), 32'd0);
    set_wr(1, 20, 20, 0, 0, 1);
    frame_start = 1;
    tick(1);
    pos_wr_en = 0; frame_start = 0;
    drive_pix(20, 20);
    tick(2);
    chk("commit_color", 32'(out_color), 32'h77);
    chk("commit_sprite", 32'(out_sprite), 32'd1);

    // Frame_start right behind a pixel must not disturb it.
    drive_pix(21, 20);
    set_wr(1, 500, 300, 0, 0, 1);
    frame_start = 1;
    tick(1);
    pos_wr_en = 0; frame_start = 0;
    tick(1);
    chk("midpipe_color", 32'(out_color), 32'h42);
    chk("midpipe_opaque", 32'(out_opaque), 32'd1);

    // Random phase: drain, refill ROMs, reset, then mixed traffic.
    tick(3);
    for (int a = 0; a < 4096; a++) begin
      rom0[a] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rom1[a] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
    reset = 1;
    tick(1);
    reset = 0;
    wr(0, 300, 200, 1, 0, 1);
    wr(1, 310, 210, 3, 1, 1);
    fs();
    for (int i = 0; i < 3000; i++) begin
      pos_wr_en = 0; frame_start = 0; reset = 0;
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) == 0)
          set_wr(1'($urandom_range(0, 1)), int'($urandom_range(280, 360)),
                 int'($urandom_range(180, 240)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
        else
          set_wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 39) == 0) frame_start = 1;
      if (i == 1500) reset = 1;
      pix_valid = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) < 7) begin
        pix_x = 10'($urandom_range(280, 400));
        pix_y = 9'($urandom_range(180, 280));
      end else begin
        pix_x = 10'($urandom_range(0, 1023));
        pix_y = 9'($urandom_range(0, 511));
      end
      tick(1);
    end
    pos_wr_en = 0; frame_start = 0; pix_valid = 0; reset = 0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
